spi_sram_line_cache: RTL and testbench

- Direct-mapped, write-through word cache between the SERV core's memory Wishbone port and the SPI SRAM controller.
- Read hits return in one cycle instead of a full SPI transaction. Misses and all writes are forwarded to the SRAM controller.
- Storage is flop-based. No macro is used.

---
 rtl/spi_sram_line_cache.sv | 129 ++++++++++++
 tb/tb_spi_sram_line_cache.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_sram_line_cache.sv
// Direct-mapped, write-through, one-word-per-line read cache in front of the
// SPI SRAM controller. Read hits answer in one cycle; misses and writes go out.
module spi_sram_line_cache #(
  parameter int LINES = 8,
  parameter int AW    = 14
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          s_cyc,
  input  logic [AW-1:0] s_adr,
  input  logic          s_we,
  input  logic [31:0]   s_dat_i,
  input  logic [3:0]    s_sel,
  output logic [31:0]   s_dat_o,
  output logic          s_ack,
  output logic          m_cyc,
  output logic [AW-1:0] m_adr,
  output logic          m_we,
  output logic [31:0]   m_dat_o,
  output logic [3:0]    m_sel,
  input  logic [31:0]   m_dat_i,
  input  logic          m_ack,
  output logic [15:0]   hit_cnt,
  output logic [15:0]   miss_cnt
);
  localparam int IW = $clog2(LINES);
  localparam int TW = AW - IW;

  typedef enum logic [1:0] {IDLE, MEM, RESP, GAP} state_t;
  state_t state, state_nx;

  logic [LINES-1:0] valid;
  logic [TW-1:0]    tag_arr  [LINES];
  logic [31:0]      data_arr [LINES];
  logic             flush_pending;

  logic [IW-1:0] s_idx, m_idx;
  logic [TW-1:0] s_tag, m_tag;
  logic          s_hit, m_hit, req, mem_done, fill_en, merge_en;
  logic [31:0]   merged;

  assign s_idx    = s_adr[IW-1:0];
  assign s_tag    = s_adr[AW-1:IW];
  assign m_idx    = m_adr[IW-1:0];
  assign m_tag    = m_adr[AW-1:IW];
  assign s_hit    = valid[s_idx] && (tag_arr[s_idx] == s_tag);
  assign m_hit    = valid[m_idx] && (tag_arr[m_idx] == m_tag);
  assign req      = (state == IDLE) && s_cyc;
  assign mem_done = (state == MEM) && m_ack;
  // A flush seen anywhere in the access (or on the completing edge) kills the update.
  assign fill_en  = mem_done && !m_we && !flush && !flush_pending;
  assign merge_en = mem_done && m_we && m_hit && !flush && !flush_pending;

  always_comb begin
    merged = data_arr[m_idx];
    for (int b = 0; b < 4; b++)
      if (m_sel[b]) merged[8*b +: 8] = m_dat_o[8*b +: 8];
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;

  always_comb begin
    state_nx = state;
    s_ack    = 1'b0;
    case (state)
      IDLE: if (s_cyc) state_nx = (!s_we && s_hit) ? RESP : MEM;
      MEM:  if (m_ack) state_nx = RESP;
      RESP: begin
        s_ack    = 1'b1;
        state_nx = GAP;
      end
      GAP:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      s_dat_o       <= '0;
      m_cyc         <= 1'b0;
      m_adr         <= '0;
      m_we          <= 1'b0;
      m_dat_o       <= '0;
      m_sel         <= '0;
      hit_cnt       <= '0;
      miss_cnt      <= '0;
      valid         <= '0;
      flush_pending <= 1'b0;
    end else begin
      if (req) begin
        if (s_we) begin
          m_cyc   <= 1'b1;
          m_adr   <= s_adr;
          m_we    <= 1'b1;
          m_dat_o <= s_dat_i;
          m_sel   <= s_sel;
        end else if (s_hit) begin
          s_dat_o <= data_arr[s_idx];
          if (hit_cnt != 16'hFFFF) hit_cnt <= hit_cnt + 16'd1;
        end else begin
          m_cyc   <= 1'b1;
          m_adr   <= s_adr;
          m_we    <= 1'b0;
          m_sel   <= 4'hF;
          if (miss_cnt != 16'hFFFF) miss_cnt <= miss_cnt + 16'd1;
        end
      end
      if (mem_done) begin
        m_cyc <= 1'b0;
        if (!m_we) s_dat_o <= m_dat_i;
      end
      if (flush)        valid        <= '0;
      else if (fill_en) valid[m_idx] <= 1'b1;
      if ((state == MEM) && flush) flush_pending <= 1'b1;
      else if (state_nx == IDLE)   flush_pending <= 1'b0;
    end

  // Tag/data storage carries no reset; valid bits gate every use.
  always_ff @(posedge clk)
    if (fill_en) begin
      tag_arr[m_idx]  <= m_tag;
      data_arr[m_idx] <= m_dat_i;
    end else if (merge_en) begin
      data_arr[m_idx] <= merged;
    end
endmodule

// File: tb/tb_spi_sram_line_cache.sv
// Directed bench for spi_sram_line_cache: bus-driving tasks plus one task per scenario.
module tb_spi_sram_line_cache;
  localparam int AW = 14;

  logic          clk = 1'b0, rst_n = 1'b0, flush = 1'b0;
  logic          s_cyc = 1'b0, s_we = 1'b0, m_ack = 1'b0;
  logic [AW-1:0] s_adr = '0;
  logic [31:0]   s_dat_i = '0, m_dat_i = '0;
  logic [3:0]    s_sel = '0;
  logic [31:0]   s_dat_o, m_dat_o;
  logic          s_ack, m_cyc, m_we;
  logic [AW-1:0] m_adr;
  logic [3:0]    m_sel;
  logic [15:0]   hit_cnt, miss_cnt;

  int checks = 0, errors = 0;

  // Observations filled in by the driver tasks.
  int            seen;
  logic [AW-1:0] c_adr;
  logic          c_we, c_stable;
  logic [3:0]    c_sel;
  logic [31:0]   c_dat;
  logic          o_ack, o_mcyc;
  logic [31:0]   o_dat;

  always #5 clk = ~clk;

  spi_sram_line_cache #(.LINES(8), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .s_cyc(s_cyc), .s_adr(s_adr), .s_we(s_we), .s_dat_i(s_dat_i), .s_sel(s_sel),
    .s_dat_o(s_dat_o), .s_ack(s_ack),
    .m_cyc(m_cyc), .m_adr(m_adr), .m_we(m_we), .m_dat_o(m_dat_o), .m_sel(m_sel),
    .m_dat_i(m_dat_i), .m_ack(m_ack),
    .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  task automatic cpu_req(input logic [AW-1:0] a, input logic we, input logic [31:0] d, input logic [3:0] sel);
    s_adr = a; s_we = we; s_dat_i = d; s_sel = sel; s_cyc = 1'b1;
  endtask

  // Drop the strobe after the ack cycle and let RESP->GAP->IDLE pass.
  task automatic cpu_done();
    s_cyc = 1'b0; s_we = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  // Controller model: wait (bounded) for m_cyc, hold `delay` cycles, then ack
  // for one cycle with rd. flush_at picks the wait cycle to pulse flush
  // (== delay pulses it together with m_ack; -1 never).
  task automatic mem_serve(input int delay, input logic [31:0] rd, input int flush_at);
    seen = -1; c_stable = 1'b1;
    for (int i = 0; i < 64; i++) begin
      if (m_cyc === 1'b1) begin seen = i; break; end
      @(negedge clk);
    end
    if (seen < 0) return;
    c_adr = m_adr; c_we = m_we; c_sel = m_sel; c_dat = m_dat_o;
    for (int i = 0; i < delay; i++) begin
      flush = (i == flush_at);
      @(negedge clk);
      if (m_cyc !== 1'b1 || m_adr !== c_adr || m_we !== c_we || m_sel !== c_sel || m_dat_o !== c_dat)
        c_stable = 1'b0;
    end
    flush = (flush_at == delay); m_ack = 1'b1; m_dat_i = rd;
    @(negedge clk);
    m_ack = 1'b0; flush = 1'b0; m_dat_i = '0;
  endtask

  // Read expected to hit: sample the cycle right after the request edge.
  task automatic do_hit(input logic [AW-1:0] a);
    cpu_req(a, 1'b0, 32'h0, 4'h0);
    @(negedge clk);
    o_ack = s_ack; o_mcyc = m_cyc; o_dat = s_dat_o;
    cpu_done();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if ({s_ack, m_cyc, m_we, m_sel, m_adr} !== '0) begin errors++;
      $display("FAIL reset_ctrl: got ack=%b cyc=%b we=%b sel=%h adr=%h want all 0", s_ack, m_cyc, m_we, m_sel, m_adr); end
    checks++; if ({s_dat_o, m_dat_o} !== 64'h0) begin errors++;
      $display("FAIL reset_data: got s_dat_o=%h m_dat_o=%h want 0", s_dat_o, m_dat_o); end
    checks++; if ({hit_cnt, miss_cnt} !== 32'h0) begin errors++;
      $display("FAIL reset_cnt: got hit=%h miss=%h want 0", hit_cnt, miss_cnt); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_read_miss();
    cpu_req(14'h0010, 1'b0, 32'h0, 4'h0);
    mem_serve(40, 32'hDEADBEEF, -1);
    checks++; if (seen !== 1) begin errors++; $display("FAIL miss_req: m_cyc seen after %0d want 1", seen); end
    checks++; if ({c_adr, c_we, c_sel} !== {14'h0010, 1'b0, 4'hF}) begin errors++;
      $display("FAIL miss_fields: got adr=%h we=%b sel=%h want 0010/0/f", c_adr, c_we, c_sel); end
    checks++; if (c_stable !== 1'b1) begin errors++; $display("FAIL miss_stable: m_* changed before m_ack"); end
    checks++; if ({s_ack, m_cyc} !== 2'b10) begin errors++;
      $display("FAIL miss_ack: got ack=%b cyc=%b want 1/0", s_ack, m_cyc); end
    checks++; if (s_dat_o !== 32'hDEADBEEF) begin errors++; $display("FAIL miss_data: got %h want deadbeef", s_dat_o); end
    checks++; if ({hit_cnt, miss_cnt} !== {16'd0, 16'd1}) begin errors++;
      $display("FAIL miss_cnt: got hit=%0d miss=%0d want 0/1", hit_cnt, miss_cnt); end
    cpu_done();
    checks++; if (s_ack !== 1'b0) begin errors++; $display("FAIL miss_ack_once: got %b want 0", s_ack); end
  endtask

  task automatic test_read_hit();
    do_hit(14'h0010);
    checks++; if ({o_ack, o_mcyc} !== 2'b10) begin errors++;
      $display("FAIL hit_latency: got ack=%b cyc=%b want 1/0", o_ack, o_mcyc); end
    checks++; if (o_dat !== 32'hDEADBEEF) begin errors++; $display("FAIL hit_data: got %h want deadbeef", o_dat); end
    checks++; if (hit_cnt !== 16'd1) begin errors++; $display("FAIL hit_cnt: got %0d want 1", hit_cnt); end
  endtask

  task automatic test_write();
    cpu_req(14'h0010, 1'b1, 32'h000000AA, 4'b0001);
    mem_serve(3, 32'h0, -1);
    checks++; if ({c_adr, c_we, c_sel, c_dat} !== {14'h0010, 1'b1, 4'b0001, 32'h000000AA}) begin errors++;
      $display("FAIL wr_fields: got adr=%h we=%b sel=%b dat=%h want 0010/1/0001/000000aa", c_adr, c_we, c_sel, c_dat); end
    checks++; if (s_ack !== 1'b1) begin errors++; $display("FAIL wr_ack: got %b want 1", s_ack); end
    checks++; if (s_dat_o !== 32'hDEADBEEF) begin errors++; $display("FAIL wr_hold_dat: got %h want deadbeef", s_dat_o); end
    cpu_done();
    do_hit(14'h0010);
    checks++; if ({o_ack, o_mcyc, o_dat} !== {2'b10, 32'hDEADBEAA}) begin errors++;
      $display("FAIL wr_merge: got ack=%b cyc=%b dat=%h want 1/0/deadbeaa", o_ack, o_mcyc, o_dat); end
    cpu_req(14'h0020, 1'b1, 32'h12345678, 4'hF);
    mem_serve(2, 32'h0, -1);
    cpu_done();
    cpu_req(14'h0020, 1'b0, 32'h0, 4'h0);
    mem_serve(5, 32'h12345678, -1);
    checks++; if (seen !== 1) begin errors++; $display("FAIL wr_no_alloc: m_cyc seen after %0d want 1", seen); end
    checks++; if (s_dat_o !== 32'h12345678) begin errors++; $display("FAIL wr_miss_data: got %h want 12345678", s_dat_o); end
    checks++; if ({hit_cnt, miss_cnt} !== {16'd2, 16'd2}) begin errors++;
      $display("FAIL wr_cnt: got hit=%0d miss=%0d want 2/2", hit_cnt, miss_cnt); end
    cpu_done();
  endtask

  task automatic test_conflict();
    cpu_req(14'h0010, 1'b0, 32'h0, 4'h0);
    mem_serve(4, 32'hDEADBEAA, -1);
    checks++; if (seen !== 1) begin errors++; $display("FAIL conf_miss_a: m_cyc seen after %0d want 1", seen); end
    cpu_done();
    cpu_req(14'h0018, 1'b0, 32'h0, 4'h0);
    mem_serve(4, 32'h18181818, -1);
    checks++; if (seen !== 1) begin errors++; $display("FAIL conf_miss_b: m_cyc seen after %0d want 1", seen); end
    cpu_done();
    do_hit(14'h0018);
    checks++; if ({o_ack, o_mcyc, o_dat} !== {2'b10, 32'h18181818}) begin errors++;
      $display("FAIL conf_hit_b: got ack=%b cyc=%b dat=%h want 1/0/18181818", o_ack, o_mcyc, o_dat); end
    cpu_req(14'h0010, 1'b0, 32'h0, 4'h0);
    mem_serve(4, 32'hDEADBEAA, -1);
    checks++; if (seen !== 1) begin errors++; $display("FAIL conf_evicted: m_cyc seen after %0d want 1", seen); end
    checks++; if ({hit_cnt, miss_cnt} !== {16'd3, 16'd5}) begin errors++;
      $display("FAIL conf_cnt: got hit=%0d miss=%0d want 3/5", hit_cnt, miss_cnt); end
    cpu_done();
  endtask

  task automatic test_flush();
    cpu_req(14'h0005, 1'b0, 32'h0, 4'h0);
    mem_serve(3, 32'h05050505, -1);
    cpu_done();
    do_hit(14'h0005);
    checks++; if ({o_ack, o_mcyc} !== 2'b10) begin errors++;
      $display("FAIL fl_pre_hit: got ack=%b cyc=%b want 1/0", o_ack, o_mcyc); end
    // flush mid-wait: CPU still gets the data, line must not be installed
    cpu_req(14'h0030, 1'b0, 32'h0, 4'h0);
    mem_serve(10, 32'h30303030, 4);
    checks++; if ({s_ack, s_dat_o} !== {1'b1, 32'h30303030}) begin errors++;
      $display("FAIL fl_mid_data: got ack=%b dat=%h want 1/30303030", s_ack, s_dat_o); end
    cpu_done();
    cpu_req(14'h0030, 1'b0, 32'h0, 4'h0);
    mem_serve(2, 32'h30303030, -1);
    checks++; if (seen !== 1) begin errors++; $display("FAIL fl_mid_noinst: m_cyc seen after %0d want 1", seen); end
    cpu_done();
    // 0x0005 was cleared by the earlier flush; this time flush lands with m_ack
    cpu_req(14'h0005, 1'b0, 32'h0, 4'h0);
    mem_serve(3, 32'h05050505, 3);
    checks++; if (seen !== 1) begin errors++; $display("FAIL fl_old_line: m_cyc seen after %0d want 1", seen); end
    checks++; if ({s_ack, s_dat_o} !== {1'b1, 32'h05050505}) begin errors++;
      $display("FAIL fl_ack_data: got ack=%b dat=%h want 1/05050505", s_ack, s_dat_o); end
    cpu_done();
    cpu_req(14'h0005, 1'b0, 32'h0, 4'h0);
    mem_serve(2, 32'h05050505, -1);
    checks++; if (seen !== 1) begin errors++; $display("FAIL fl_ack_noinst: m_cyc seen after %0d want 1", seen); end
    cpu_done();
    do_hit(14'h0005);
    checks++; if ({o_ack, o_mcyc, o_dat} !== {2'b10, 32'h05050505}) begin errors++;
      $display("FAIL fl_refill: got ack=%b cyc=%b dat=%h want 1/0/05050505", o_ack, o_mcyc, o_dat); end
    checks++; if ({hit_cnt, miss_cnt} !== {16'd5, 16'd10}) begin errors++;
      $display("FAIL fl_cnt: got hit=%0d miss=%0d want 5/10", hit_cnt, miss_cnt); end
  endtask

  task automatic test_hold();
    int acks;
    acks = 0;
    cpu_req(14'h0005, 1'b0, 32'h0, 4'h0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (s_ack === 1'b1) acks++;
      if (i == 2) s_cyc = 1'b0;
    end
    checks++; if (acks !== 1) begin errors++; $display("FAIL hold_acks: got %0d want 1", acks); end
    checks++; if ({m_cyc, hit_cnt} !== {1'b0, 16'd6}) begin errors++;
      $display("FAIL hold_cnt: got cyc=%b hit=%0d want 0/6", m_cyc, hit_cnt); end
  endtask

  task automatic test_saturate();
    force dut.hit_cnt = 16'hFFFE;
    @(negedge clk);
    release dut.hit_cnt;
    @(negedge clk);
    checks++; if (hit_cnt !== 16'hFFFE) begin errors++; $display("FAIL sat_preload: got %h want fffe", hit_cnt); end
    do_hit(14'h0005);
    checks++; if (hit_cnt !== 16'hFFFF) begin errors++; $display("FAIL sat_first: got %h want ffff", hit_cnt); end
    do_hit(14'h0005);
    do_hit(14'h0005);
    checks++; if ({o_ack, hit_cnt, miss_cnt} !== {1'b1, 16'hFFFF, 16'd10}) begin errors++;
      $display("FAIL sat_hold: got ack=%b hit=%h miss=%0d want 1/ffff/10", o_ack, hit_cnt, miss_cnt); end
  endtask

  task automatic test_reset_mid();
    logic got;
    got = 1'b0;
    cpu_req(14'h0040, 1'b0, 32'h0, 4'h0);
    for (int i = 0; i < 8 && !got; i++) begin
      @(negedge clk);
      got = (m_cyc === 1'b1);
    end
    checks++; if (got !== 1'b1) begin errors++; $display("FAIL rst_mid_req: m_cyc never rose"); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if ({m_cyc, s_ack, hit_cnt, miss_cnt} !== '0) begin errors++;
      $display("FAIL rst_mid_async: got cyc=%b ack=%b hit=%h miss=%h want 0", m_cyc, s_ack, hit_cnt, miss_cnt); end
    s_cyc = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    cpu_req(14'h0005, 1'b0, 32'h0, 4'h0);
    mem_serve(2, 32'h05050505, -1);
    checks++; if (seen !== 1) begin errors++; $display("FAIL rst_mid_inval: m_cyc seen after %0d want 1", seen); end
    checks++; if ({s_ack, miss_cnt, hit_cnt} !== {1'b1, 16'd1, 16'd0}) begin errors++;
      $display("FAIL rst_mid_after: got ack=%b miss=%0d hit=%0d want 1/1/0", s_ack, miss_cnt, hit_cnt); end
    cpu_done();
  endtask

  initial begin
    test_reset();
    test_read_miss();
    test_read_hit();
    test_write();
    test_conflict();
    test_flush();
    test_hold();
    test_saturate();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
